// File: rtl/mem_access.sv
// Memory stage: passes non-memory instructions straight through and splits
// loads/stores into byte-serial transfers on the memory-controller port.
// Controller handshake: mctl_req is held high with a stable mctl_addr /
// mctl_wdata until the controller returns a one-cycle mctl_ack, which
// completes exactly that byte; the next byte is presented the cycle after.
module mem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_alu_val,
  input  logic [31:0] ex_st_val,
  input  logic [6:0]  ex_ins_type,
  input  logic [2:0]  ex_funct3,
  output logic        stall_req,
  output logic        mctl_req,
  output logic        mctl_wr,
  output logic [31:0] mctl_addr,
  output logic [7:0]  mctl_wdata,
  input  logic        mctl_ack,
  input  logic [7:0]  mctl_rdata,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_val,
  output logic [6:0]  ins_type,
  output logic [1:0]  state_dbg
);

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALOPI = 7'b0010011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  last_idx;   // number of bytes minus one
  logic [31:0] base;
  logic [31:0] st_data;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [6:0]  op;
  logic [31:0] rbuf;
  logic        is_mem;
  logic [31:0] load_val;

  assign is_mem    = (ex_ins_type == LOAD) || (ex_ins_type == STORE);
  assign state_dbg = state;

  // Access sequencing: latch the instruction, step through its bytes, show the result for one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      idx      <= 2'd0;
      last_idx <= 2'd0;
      base     <= 32'd0;
      st_data  <= 32'd0;
      f3       <= 3'd0;
      rd       <= 5'd0;
      op       <= 7'd0;
      rbuf     <= 32'd0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            base    <= ex_alu_val;
            st_data <= ex_st_val;
            f3      <= ex_funct3;
            rd      <= ex_rd_addr;
            op      <= ex_ins_type;
            idx     <= 2'd0;
            rbuf    <= 32'd0;
            // Width code 11 is illegal; it is handled as a full word.
            case (ex_funct3[1:0])
              2'b00:   last_idx <= 2'd0;
              2'b01:   last_idx <= 2'd1;
              default: last_idx <= 2'd3;
            endcase
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mctl_ack) begin
            if (op == LOAD) rbuf[{idx, 3'b000} +: 8] <= mctl_rdata;
            if (idx == last_idx) state <= DONE;
            else                 idx   <= idx + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Width/sign extension of the assembled load data.
  always_comb begin
    load_val = rbuf;
    case (f3[1:0])
      2'b00:   load_val = f3[2] ? {24'd0, rbuf[7:0]}  : {{24{rbuf[7]}}, rbuf[7:0]};
      2'b01:   load_val = f3[2] ? {16'd0, rbuf[15:0]} : {{16{rbuf[15]}}, rbuf[15:0]};
      default: load_val = rbuf;
    endcase
  end

  // Output selection: pass-through, bubble with stall, byte request, or result.
  always_comb begin
    stall_req  = 1'b0;
    mctl_req   = 1'b0;
    mctl_wr    = 1'b0;
    mctl_addr  = 32'd0;
    mctl_wdata = 8'd0;
    rd_addr    = 5'd0;
    rd_val     = 32'd0;
    ins_type   = ALOPI;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            stall_req = 1'b1;
          end else begin
            rd_addr  = ex_rd_addr;
            rd_val   = ex_alu_val;
            ins_type = ex_ins_type;
          end
        end
        BUSY: begin
          stall_req  = 1'b1;
          mctl_req   = 1'b1;
          mctl_wr    = (op == STORE);
          mctl_addr  = base + {30'd0, idx};
          mctl_wdata = st_data[{idx, 3'b000} +: 8];
        end
        DONE: begin
          if (op == LOAD) begin
            ins_type = LOAD;
            rd_addr  = rd;
            rd_val   = load_val;
          end else begin
            ins_type = STORE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction-level reference model compared against
// every output on every cycle, a byte-addressable memory behind the
// controller port, directed scenarios with literal expectations, and a
// randomized instruction stream.
module tb_mem_access;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALOPI = 7'b0010011;
  localparam logic [6:0] ALU_R = 7'b0110011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_alu_val;
  logic [31:0] ex_st_val;
  logic [6:0]  ex_ins_type;
  logic [2:0]  ex_funct3;
  logic        stall_req;
  logic        mctl_req;
  logic        mctl_wr;
  logic [31:0] mctl_addr;
  logic [7:0]  mctl_wdata;
  logic        mctl_ack;
  logic [7:0]  mctl_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  mem_access dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ex_rd_addr(ex_rd_addr), .ex_alu_val(ex_alu_val), .ex_st_val(ex_st_val),
    .ex_ins_type(ex_ins_type), .ex_funct3(ex_funct3),
    .stall_req(stall_req), .mctl_req(mctl_req), .mctl_wr(mctl_wr),
    .mctl_addr(mctl_addr), .mctl_wdata(mctl_wdata),
    .mctl_ack(mctl_ack), .mctl_rdata(mctl_rdata),
    .rd_addr(rd_addr), .rd_val(rd_val), .ins_type(ins_type),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- memory behind the controller ----------------
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] ack_addr_q [$];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic bit is_mem_op(input logic [6:0] o);
    return (o == LOAD) || (o == STORE);
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int          xfer = 0;        // bytes still to be moved for the instruction in flight
  bit          show_res = 0;    // result of the finished access is on the outputs
  int          m_n;
  bit          m_load;
  bit          m_signed;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_rd;
  logic [7:0]  got_q [$];

  function automatic logic [31:0] load_result();
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < m_n; k++) v = v + (64'(got_q[k]) << (8 * k));
    if (m_signed && m_n < 4 && got_q[m_n-1][7]) v = v - (64'd1 << (8 * m_n));
    return v[31:0];
  endfunction

  always @(posedge clk_in) begin
    if (rst_in) begin
      xfer = 0;
      show_res = 0;
      got_q.delete();
    end else if (rdy_in) begin
      if (show_res) begin
        show_res = 0;
      end else if (xfer > 0) begin
        if (mctl_ack) begin
          got_q.push_back(mctl_rdata);
          xfer = xfer - 1;
          if (xfer == 0) show_res = 1;
        end
      end else if (is_mem_op(ex_ins_type)) begin
        m_n      = (ex_funct3[1:0] == 2'b00) ? 1 : (ex_funct3[1:0] == 2'b01) ? 2 : 4;
        m_load   = (ex_ins_type == LOAD);
        m_signed = !ex_funct3[2];
        m_addr   = ex_alu_val;
        m_data   = ex_st_val;
        m_rd     = ex_rd_addr;
        got_q.delete();
        xfer = m_n;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        e_stall, e_req, e_wr;
  logic [31:0] e_addr, e_val;
  logic [7:0]  e_wdata;
  logic [4:0]  e_rd;
  logic [6:0]  e_ins;
  logic [86:0] e_vec, a_vec;
  int          cur_k;

  always @(negedge clk_in) begin
    e_stall = 0; e_req = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
    e_rd = 0; e_val = 0; e_ins = ALOPI;
    if (!rst_in) begin
      if (show_res) begin
        if (m_load) begin
          e_ins = LOAD; e_rd = m_rd; e_val = load_result();
        end else begin
          e_ins = STORE;
        end
      end else if (xfer > 0) begin
        cur_k   = m_n - xfer;
        e_stall = 1; e_req = 1; e_wr = !m_load;
        e_addr  = m_addr + 32'(cur_k);
        e_wdata = 8'(m_data >> (8 * cur_k));
      end else if (is_mem_op(ex_ins_type)) begin
        e_stall = 1;
      end else begin
        e_rd = ex_rd_addr; e_val = ex_alu_val; e_ins = ex_ins_type;
      end
    end
    e_vec = {e_stall, e_req, e_wr, e_addr, e_wdata, e_rd, e_val, e_ins};
    a_vec = {stall_req, mctl_req, mctl_wr, mctl_addr, mctl_wdata, rd_addr, rd_val, ins_type};
    checks++;
    if (a_vec !== e_vec) begin
      failures++;
      $display("FAIL cycle t=%0t actual stall/req/wr/addr/wdata/rd/val/ins=%0b/%0b/%0b/%h/%h/%0d/%h/%b required=%0b/%0b/%0b/%h/%h/%0d/%h/%b",
               $time, stall_req, mctl_req, mctl_wr, mctl_addr, mctl_wdata, rd_addr, rd_val, ins_type,
               e_stall, e_req, e_wr, e_addr, e_wdata, e_rd, e_val, e_ins);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents one instruction from EX/MEM and plays the controller until the
  // stage lets it go (or until a planted reset/timeout ends it).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int wmin, input int wmax, input int drop_at, input int rst_at,
                           output logic [31:0] r_val, output logic [4:0] r_rd,
                           output logic [6:0] r_ins, output int stalls);
    int cyc;
    int wcnt;
    ex_ins_type = op; ex_funct3 = f3; ex_rd_addr = rd; ex_alu_val = a; ex_st_val = sd;
    stalls = 0; cyc = 0; r_val = 0; r_rd = 0; r_ins = 0;
    wcnt = $urandom_range(wmin, wmax);
    ack_addr_q.delete();
    forever begin
      mctl_ack = 1'b0;
      rdy_in = !(drop_at >= 0 && cyc >= drop_at && cyc < drop_at + 2);
      if (cyc == rst_at) rst_in = 1'b1;
      #1;
      mctl_rdata = 8'($urandom);
      if (!rdy_in) begin
        mctl_ack = 1'b1;          // stray pulse that must be ignored
      end else if (mctl_req && !rst_in) begin
        if (wcnt == 0) begin
          mctl_ack = 1'b1;
          ack_addr_q.push_back(mctl_addr);
          if (mctl_wr) mem[mctl_addr] = mctl_wdata;
          else         mctl_rdata = mem_rd(mctl_addr);
          wcnt = $urandom_range(wmin, wmax);
        end else begin
          wcnt--;
        end
      end
      @(negedge clk_in);
      if (stall_req) stalls++;
      if (cyc == rst_at) begin
        chk("reset_stall_low", 32'(stall_req), 32'd0);
        chk("reset_req_low", 32'(mctl_req), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0; mctl_ack = 1'b0; rdy_in = 1'b1;
        return;
      end
      if (!stall_req && rdy_in) begin
        r_val = rd_val; r_rd = rd_addr; r_ins = ins_type;
        @(posedge clk_in); #1;
        mctl_ack = 1'b0;
        return;
      end
      cyc++;
      if (cyc > 200) begin
        checks++; failures++;
        $display("FAIL timeout actual=stalled required=release op=%b", op);
        @(posedge clk_in); #1;
        mctl_ack = 1'b0; rdy_in = 1'b1;
        return;
      end
      @(posedge clk_in); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rv;
  logic [4:0]  rr;
  logic [6:0]  ri;
  int          st;
  logic [6:0]  alu_ops [5] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111, 7'b1100011};

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mctl_ack = 1'b0; mctl_rdata = 8'd0;
    ex_ins_type = ALU_R; ex_funct3 = 3'd0; ex_rd_addr = 5'd3; ex_alu_val = 32'h55; ex_st_val = 32'd0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_ins_type", 32'(ins_type), 32'(ALOPI));
    chk("reset_rd_val", rd_val, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // ALU pass-through
    run_instr(ALU_R, 3'd0, 5'd5, 32'h1234, 32'd0, 0, 0, -1, -1, rv, rr, ri, st);
    chk("alu_val", rv, 32'h1234);
    chk("alu_rd", 32'(rr), 32'd5);
    chk("alu_stalls", 32'(st), 32'd0);

    // LW zero-wait
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_instr(LOAD, 3'b010, 5'd9, 32'h100, 32'd0, 0, 0, -1, -1, rv, rr, ri, st);
    chk("lw_val", rv, 32'h12345678);
    chk("lw_rd", 32'(rr), 32'd9);
    chk("lw_ins", 32'(ri), 32'(LOAD));
    chk("lw_stalls", 32'(st), 32'd5);
    chk("lw_nbytes", 32'(ack_addr_q.size()), 32'd4);
    if (ack_addr_q.size() == 4) begin
      chk("lw_addr0", ack_addr_q[0], 32'h100);
      chk("lw_addr3", ack_addr_q[3], 32'h103);
    end

    // LB / LBU / LH
    mem[32'h300] = 8'h80;
    run_instr(LOAD, 3'b000, 5'd1, 32'h300, 32'd0, 0, 2, -1, -1, rv, rr, ri, st);
    chk("lb_val", rv, 32'hFFFFFF80);
    run_instr(LOAD, 3'b100, 5'd1, 32'h300, 32'd0, 0, 2, -1, -1, rv, rr, ri, st);
    chk("lbu_val", rv, 32'h00000080);
    mem[32'h310] = 8'hFE; mem[32'h311] = 8'hFF;
    run_instr(LOAD, 3'b001, 5'd2, 32'h310, 32'd0, 0, 0, -1, -1, rv, rr, ri, st);
    chk("lh_val", rv, 32'hFFFFFFFE);

    // SH with three wait cycles per byte
    run_instr(STORE, 3'b001, 5'd4, 32'h200, 32'hAABBCCDD, 3, 3, -1, -1, rv, rr, ri, st);
    chk("sh_mem0", 32'(mem_rd(32'h200)), 32'hDD);
    chk("sh_mem1", 32'(mem_rd(32'h201)), 32'hCC);
    chk("sh_nbytes", 32'(ack_addr_q.size()), 32'd2);
    chk("sh_rd", 32'(rr), 32'd0);
    chk("sh_ins", 32'(ri), 32'(STORE));

    // SW across the address wrap, with rdy dropped mid-access
    run_instr(STORE, 3'b010, 5'd6, 32'hFFFFFFFE, 32'h11223344, 0, 0, 2, -1, rv, rr, ri, st);
    chk("sw_wrap_fe", 32'(mem_rd(32'hFFFFFFFE)), 32'h44);
    chk("sw_wrap_ff", 32'(mem_rd(32'hFFFFFFFF)), 32'h33);
    chk("sw_wrap_00", 32'(mem_rd(32'h0)), 32'h22);
    chk("sw_wrap_01", 32'(mem_rd(32'h1)), 32'h11);

    // Reset in the middle of a LW, then an ALU op passes immediately
    run_instr(LOAD, 3'b010, 5'd9, 32'h100, 32'd0, 1, 1, -1, 4, rv, rr, ri, st);
    run_instr(ALU_R, 3'd0, 5'd7, 32'hCAFE, 32'd0, 0, 0, -1, -1, rv, rr, ri, st);
    chk("post_reset_val", rv, 32'hCAFE);
    chk("post_reset_stalls", 32'(st), 32'd0);

    // Randomized stream
    for (int i = 0; i < 200; i++) begin
      int          sel;
      int          drop;
      logic [6:0]  op;
      logic [31:0] addr;
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? alu_ops[$urandom_range(0, 4)] : (sel == 1) ? LOAD : STORE;
      case ($urandom_range(0, 2))
        0:       addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        1:       addr = 32'h100 + 32'($urandom_range(0, 31));
        default: addr = $urandom;
      endcase
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(op, 3'($urandom_range(0, 7)), 5'($urandom), addr, $urandom,
                0, $urandom_range(0, 3), drop, -1, rv, rr, ri, st);
    end

    repeat (2) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
